mem_responder: RTL and testbench

- Memory-side responder for the core's instruction-fetch and load/store requests.
- Replaces the combinational DPI fetch path with a valid/ready request/response handshake.
- Word-addressed SRAM model with byte-masked writes, a programmable fixed access latency and error reporting.
- Sits between IFU/LSU initiators and backing storage; IFU and LSU move to multi-cycle operation against it.

---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared types and constants for the memory responder.
//   state_t  : responder FSM states
//   MEM_BASE : default byte address of storage word 0 (PC reset vector)
//   resp_t   : response payload captured when a request is serviced
package mem_responder_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
//   DEPTH x DATA_W word storage with a byte-masked synchronous write port
//   and a combinational read port. Contents are not reset; the
//   surrounding environment is responsible for loading an initial image.
//   Ports:
//     clk    in   clock, rising edge
//     we     in   write enable
//     addr   in   word index (shared by read and write)
//     wdata  in   write data
//     wmask  in   per-byte write enables
//     rdata  out  word at addr, combinational (pre-write value on a write edge)
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wmask[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Valid/ready memory responder for instruction-fetch and load/store
//   initiators. A request is accepted in IDLE, waits LATENCY cycles, is
//   then serviced against mem_array (address check, masked write or read)
//   and the response is held until the initiator takes it. One request is
//   outstanding at a time.
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     req_valid     in   request present
//     req_ready     out  responder idle and able to accept (registered)
//     req_addr      in   byte address
//     req_wen       in   1 = write, 0 = read
//     req_wdata     in   write data
//     req_wmask     in   byte enables for writes
//     resp_valid    out  response available
//     resp_ready    in   initiator takes the response
//     resp_rdata    out  read data; 0 for writes and errors
//     resp_err      out  misaligned or out-of-range access
//   LATENCY must lie in 0..15; resp_valid rises LATENCY+1 cycles after the
//   acceptance edge.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(MEM_BASE),
  parameter int                LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_wen,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = DATA_W/8;
  // One bit wider than the address so BASE+4*DEPTH cannot wrap.
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(4*DEPTH);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [ADDR_W-1:0] addr_p0;
  logic              wen_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [MW-1:0]     wmask_p0;

  logic              accept;
  logic              respond;
  logic              handshake;
  logic              addr_err;
  logic              mem_we;
  logic [ADDR_W-1:0] offset;
  logic [AW-1:0]     word_idx;
  logic [DATA_W-1:0] mem_rdata;
  resp_t             resp_n;

  assign accept    = req_valid & req_ready;
  // The service edge is the first edge spent in RESP: storage is touched
  // and the response captured exactly once, as resp_valid rises.
  assign respond   = (state == RESP) & ~resp_valid;
  assign handshake = resp_valid & resp_ready;

  // Below-BASE addresses wrap in the subtraction; the compare catches them
  // so the truncated index is never used for an erroring access.
  assign offset   = addr_p0 - BASE;
  assign word_idx = AW'(offset >> 2);
  assign addr_err = (addr_p0[1:0] != 2'b00) | (addr_p0 < BASE) |
                    ({1'b0, addr_p0} >= LIMIT);
  assign mem_we   = respond & wen_p0 & ~addr_err;

  always_comb begin
    resp_n.err   = addr_err;
    resp_n.rdata = (wen_p0 | addr_err) ? '0 : mem_rdata;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (wdata_p0),
    .wmask (wmask_p0),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP: begin
        if (handshake) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Request capture (p0) and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0    <= '0;
      wen_p0     <= 1'b0;
      wdata_p0   <= '0;
      wmask_p0   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready <= (state_n == IDLE);
      if (accept) begin
        addr_p0  <= req_addr;
        wen_p0   <= req_wen;
        wdata_p0 <= req_wdata;
        wmask_p0 <= req_wmask;
      end
      if (respond) begin
        resp_valid <= 1'b1;
        resp_rdata <= resp_n.rdata;
        resp_err   <= resp_n.err;
      end else if (handshake) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder: a LATENCY=2 instance (u_dut) and a
//   LATENCY=0 instance (u_dut0) sharing clock and reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  logic        l0_req_valid = 1'b0, l0_req_ready, l0_req_wen = 1'b0;
  logic [31:0] l0_req_addr = '0, l0_req_wdata = '0;
  logic [3:0]  l0_req_wmask = '0;
  logic        l0_resp_valid, l0_resp_ready = 1'b0, l0_resp_err;
  logic [31:0] l0_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.LATENCY(0), .DEPTH(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(l0_req_valid), .req_ready(l0_req_ready), .req_addr(l0_req_addr),
    .req_wen(l0_req_wen), .req_wdata(l0_req_wdata), .req_wmask(l0_req_wmask),
    .resp_valid(l0_resp_valid), .resp_ready(l0_resp_ready),
    .resp_rdata(l0_resp_rdata), .resp_err(l0_resp_err)
  );

  task automatic set_req(input bit sel, input logic v, input logic [31:0] a,
                         input logic w, input logic [31:0] d, input logic [3:0] m);
    if (sel) begin
      l0_req_valid = v; l0_req_addr = a; l0_req_wen = w; l0_req_wdata = d; l0_req_wmask = m;
    end else begin
      req_valid = v; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
    end
  endtask

  task automatic set_rr(input bit sel, input logic v);
    if (sel) l0_resp_ready = v;
    else     resp_ready    = v;
  endtask

  // Full transaction: present, wait for acceptance, count edges from the
  // acceptance edge until resp_valid, capture, then take the response.
  // cyc = -1 when acceptance or response never arrives within the bound.
  task automatic txn(input bit sel, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd, output logic er, output int cyc);
    logic rdy;
    int   k;
    set_req(sel, 1'b1, a, w, d, m);
    rdy = 1'b0;
    k   = 0;
    while (!rdy && k < 20) begin
      @(negedge clk);
      rdy = sel ? l0_req_ready : req_ready;
      @(posedge clk);
      k++;
    end
    #1;
    set_req(sel, 1'b0, a, w, d, m);
    cyc = -1;
    rd  = 'x;
    er  = 1'bx;
    if (rdy) begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        if (sel ? l0_resp_valid : resp_valid) begin
          cyc = c;
          break;
        end
      end
      if (cyc > 0) begin
        rd = sel ? l0_resp_rdata : resp_rdata;
        er = sel ? l0_resp_err : resp_err;
        set_rr(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rr(sel, 1'b0);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_req_ready: got %b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_resp_valid: got %b want 0", resp_valid); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
  endtask

  task automatic test_read;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    // Load the image words used by later tests.
    txn(0, 32'h8000_0000, 1'b1, 32'h0000_0413, 4'hF, rd, er, cyc);
    n_tests++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL load0: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", cyc); end
    txn(0, 32'h8000_0004, 1'b1, 32'h1122_3344, 4'hF, rd, er, cyc);
    n_tests++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL load1: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    txn(0, 32'h8000_0008, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er, cyc);
    n_tests++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL load2: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", cyc); end
    n_tests++; if (rd !== 32'h0000_0413) begin n_fail++; $display("FAIL read_rdata: got %h want 00000413", rd); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", er); end
  endtask

  task automatic test_byte_mask;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    txn(0, 32'h8000_0004, 1'b1, 32'hDEAD_BEEF, 4'b0101, rd, er, cyc);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL mask_write_err: got %b want 0", er); end
    txn(0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (rd !== 32'h11AD_33EF) begin n_fail++; $display("FAIL mask_readback: got %h want 11ad33ef", rd); end
    txn(0, 32'h8000_0004, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, er, cyc);
    n_tests++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL mask0_write: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    txn(0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (rd !== 32'h11AD_33EF) begin n_fail++; $display("FAIL mask0_readback: got %h want 11ad33ef", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    txn(0, 32'h8000_0002, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_misaligned: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    txn(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_below_base: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    txn(0, 32'h8000_4000, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_above_top: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    // Last legal word; the below-base write would alias onto it if wrapped.
    txn(0, 32'h8000_3FFC, 1'b1, 32'h0BAD_F00D, 4'hF, rd, er, cyc);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_write_err: got %b want 0", er); end
    txn(0, 32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, cyc);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_below_base_write: got %b want 1", er); end
    txn(0, 32'h8000_3FFC, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin n_fail++; $display("FAIL last_word_unchanged: got %h err=%b want 0badf00d err=0", rd, er); end
    txn(0, 32'h8000_0006, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, cyc);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_write: got %b want 1", er); end
    txn(0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (rd !== 32'h11AD_33EF) begin n_fail++; $display("FAIL misaligned_write_no_change: got %h want 11ad33ef", rd); end
  endtask

  task automatic test_backpressure;
    logic got;
    int   cyc;
    set_req(0, 1'b1, 32'h8000_0008, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_before: got %b want 1", req_ready); end
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    got = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin got = 1'b1; break; end
    end
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_resp_timeout: got no resp_valid want resp_valid"); end
    // A second request arrives while the first response is stalled.
    set_req(0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, resp_valid); end
      n_tests++; if (resp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp_hold_rdata[%0d]: got %h want cafef00d", i, resp_rdata); end
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_hs_valid: got %b want 0", resp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs_ready: got %b want 1", req_ready); end
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got ready=%b want 0", req_ready); end
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin cyc = c; break; end
    end
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 3", cyc); end
    n_tests++; if (resp_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL bp_second_rdata: got %h want 00000413", resp_rdata); end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    set_req(0, 1'b1, 32'h8000_0008, 1'b1, 32'h1234_5678, 4'hF);
    @(negedge clk);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wait_rst_ready: got %b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wait_rst_valid: got %b want 0", resp_valid); end
    n_tests++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL wait_rst_data: got rdata=%h err=%b want 0/0", resp_rdata, resp_err); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    txn(0, 32'h8000_0008, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait_rst_no_commit: got %h want cafef00d", rd); end
  endtask

  task automatic test_latency0;
    logic [31:0] rd;
    logic        er;
    int          cyc;
    txn(1, 32'h8000_0010, 1'b1, 32'hA5A5_5A5A, 4'hF, rd, er, cyc);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL l0_write_latency: got %0d want 1", cyc); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL l0_write_err: got %b want 0", er); end
    txn(1, 32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL l0_read_latency: got %0d want 1", cyc); end
    n_tests++; if (rd !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL l0_read_rdata: got %h want a5a55a5a", rd); end
    txn(1, 32'h8000_0040, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL l0_err_top: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_mask();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_latency0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
